// File: rtl/mlp_cfg_infer_ctrl_pkg.sv
// Shared types and helpers for the MLP config/inference sequencer.
// Holds the FSM state encoding and the config-image byte-count calculation.
package mlp_cfg_infer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EVAL  = 3'd3,
    ST_HOLD  = 3'd4
  } ctrl_state_t;

  localparam int unsigned CNT_W = 6;

  function automatic int unsigned cfg_bytes(input int unsigned img_w);
    return (img_w + 7) / 8;
  endfunction

endpackage

// File: rtl/mlp_cfg_shadow.sv
// Byte-addressed shadow copy of the weight/bias image with atomic commit.
// The commit edge also captures the byte being written on that same edge.
module mlp_cfg_shadow
  import mlp_cfg_infer_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = 315,
  parameter int unsigned NCFG  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  output logic [IMG_W-1:0] active_img
);

  logic [NCFG*8-1:0] shadow;
  logic [NCFG*8-1:0] shadow_nxt;

  always_comb begin
    shadow_nxt = shadow;
    for (int unsigned i = 0; i < NCFG; i++) begin
      if (wr_en && (wr_idx == CNT_W'(i))) begin
        shadow_nxt[i*8 +: 8] = wr_data;
      end
    end
  end

  // Pad bits above IMG_W live in the shadow only and never reach the active image.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      active_img <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (commit) begin
        active_img <= shadow_nxt[IMG_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mlp_cfg_infer_ctrl.sv
// Sequencer for the runtime-weighted MLP core: loads the weight/bias image,
// holds each sample stable for a fixed evaluation window and returns the class.
module mlp_cfg_infer_ctrl
  import mlp_cfg_infer_ctrl_pkg::*;
#(
  parameter int unsigned INP_W       = 28,
  parameter int unsigned WGT_W       = 240,
  parameter int unsigned BIAS_W      = 75,
  parameter int unsigned OUT_W       = 2,
  parameter int unsigned EVAL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_data,
  input  logic              cfg_last,
  output logic              cfg_loaded,
  output logic              cfg_err,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [INP_W-1:0]  smp_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_class,
  output logic [INP_W-1:0]  core_inp,
  output logic [WGT_W-1:0]  core_weights,
  output logic [BIAS_W-1:0] core_biases,
  input  logic [OUT_W-1:0]  core_out
);

  localparam int unsigned IMG_W = WGT_W + BIAS_W;
  localparam int unsigned NCFG  = cfg_bytes(IMG_W);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NCFG - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NCFG);
  localparam logic [3:0]       EVAL_LAST = 4'(EVAL_CYCLES - 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] byte_cnt;
  logic [3:0]       eval_cnt;
  logic             cfg_fire;
  logic             smp_fire;
  logic             sh_wr_en;
  logic             sh_commit;
  logic [CNT_W-1:0] sh_wr_idx;
  logic [IMG_W-1:0] active_img;

  // Config wins over a simultaneous sample in IDLE; no config is taken while evaluating.
  assign cfg_ready = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DRAIN);
  assign smp_ready = (state == ST_IDLE) && cfg_loaded && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign smp_fire  = smp_valid && smp_ready;

  assign sh_wr_en  = cfg_fire && ((state == ST_IDLE) || (state == ST_LOAD));
  assign sh_wr_idx = (state == ST_IDLE) ? '0 : byte_cnt;
  assign sh_commit = cfg_fire && (state == ST_LOAD) && cfg_last && (byte_cnt == LAST_IDX);

  mlp_cfg_shadow #(
    .IMG_W(IMG_W),
    .NCFG (NCFG)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (sh_wr_en),
    .wr_idx    (sh_wr_idx),
    .wr_data   (cfg_data),
    .commit    (sh_commit),
    .active_img(active_img)
  );

  assign core_weights = active_img[WGT_W-1:0];
  assign core_biases  = active_img[IMG_W-1:WGT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      eval_cnt   <= '0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      core_inp   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            byte_cnt <= CNT_W'(1);
            if (cfg_last) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              state   <= ST_LOAD;
            end
          end else if (smp_fire) begin
            core_inp <= smp_data;
            eval_cnt <= '0;
            state    <= ST_EVAL;
          end
        end
        ST_LOAD: begin
          if (cfg_fire) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (cfg_last) begin
              if (byte_cnt == LAST_IDX) begin
                cfg_loaded <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
              state <= ST_IDLE;
            end else if (byte_cnt == LAST_IDX) begin
              cfg_err <= 1'b1;
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (cfg_fire) begin
            if (byte_cnt != FULL_CNT) begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (cfg_last) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_EVAL: begin
          eval_cnt <= eval_cnt + 4'd1;
          if (eval_cnt == EVAL_LAST) begin
            res_class <= core_out;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
